perceptron_train_ctrl: RTL and testbench

PERCEPTRON_TRAIN_CTRL -- requirements
Module: perceptron_train_ctrl

---
 rtl/perceptron_train_ctrl.sv | 158 +++++++++++++++
 tb/tb_perceptron_train_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_train_ctrl.sv
// Training-sequence controller for a two-input perceptron: buffers a sample set, replays it
// epoch by epoch into the neuron datapath, and stops on a clean epoch or the epoch limit.
module perceptron_train_ctrl #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned MAX_EPOCHS = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] n_samples,
  input  logic       wr_en,
  input  logic [6:0] wr_x1,
  input  logic [6:0] wr_x2,
  input  logic [1:0] wr_t,
  output logic       load_ready,
  output logic       dp_valid,
  output logic [6:0] dp_x1,
  output logic [6:0] dp_x2,
  output logic [1:0] dp_t,
  input  logic       dp_ready,
  input  logic       dp_ack,
  input  logic       dp_err,
  output logic       dp_epoch_start,
  output logic [7:0] epoch,
  output logic       done,
  output logic       converged
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]  DepthW = 7'(DEPTH);
  localparam logic [7:0]  MaxEp  = 8'(MAX_EPOCHS);

  typedef enum logic [2:0] {
    StIdle, StLoad, StPresent, StWaitAck, StEpochEnd, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  n_q, n_d;
  logic [6:0]  wptr_q, wptr_d;
  logic [6:0]  rptr_q, rptr_d;
  logic [7:0]  epoch_q, epoch_d;
  logic        err_q, err_d;
  logic        conv_q, conv_d;
  logic        eps_q, eps_d;
  logic [15:0] mem [DEPTH];
  logic [15:0] rd_word;
  logic        start_ok;

  assign start_ok = start && (n_samples != 7'd0) && (n_samples <= DepthW);
  assign rd_word  = mem[rptr_q[AW-1:0]];

  // Sample buffer has no reset so its contents survive across runs.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StLoad && wr_en) begin
      mem[wptr_q[AW-1:0]] <= {wr_x1, wr_x2, wr_t};
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    epoch_d = epoch_q;
    err_d   = err_q;
    conv_d  = conv_q;
    eps_d   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          state_d = StLoad;
          n_d     = n_samples;
          wptr_d  = 7'd0;
          rptr_d  = 7'd0;
          epoch_d = 8'd0;
          err_d   = 1'b0;
          conv_d  = 1'b0;
        end
      end
      StLoad: begin
        if (wr_en) begin
          wptr_d = wptr_q + 7'd1;
          if (wptr_q + 7'd1 == n_q) begin
            state_d = StPresent;
            rptr_d  = 7'd0;
            eps_d   = 1'b1;
          end
        end
      end
      StPresent: begin
        if (dp_ready) state_d = StWaitAck;
      end
      StWaitAck: begin
        if (dp_ack) begin
          err_d = err_q | dp_err;
          if (rptr_q == n_q - 7'd1) begin
            state_d = StEpochEnd;
          end else begin
            rptr_d  = rptr_q + 7'd1;
            state_d = StPresent;
          end
        end
      end
      StEpochEnd: begin
        epoch_d = (epoch_q == 8'hFF) ? 8'hFF : epoch_q + 8'd1;
        if (!err_q) begin
          state_d = StDone;
          conv_d  = 1'b1;
        end else if (epoch_q + 8'd1 == MaxEp) begin
          state_d = StDone;
          conv_d  = 1'b0;
        end else begin
          err_d   = 1'b0;
          rptr_d  = 7'd0;
          state_d = StPresent;
          eps_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= 7'd0;
      wptr_q  <= 7'd0;
      rptr_q  <= 7'd0;
      epoch_q <= 8'd0;
      err_q   <= 1'b0;
      conv_q  <= 1'b0;
      eps_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      epoch_q <= epoch_d;
      err_q   <= err_d;
      conv_q  <= conv_d;
      eps_q   <= eps_d;
    end
  end

  // Sample fields are zeroed outside PRESENT so undefined buffer contents never leak out.
  always_comb begin
    load_ready     = (state_q == StLoad);
    dp_valid       = (state_q == StPresent);
    dp_x1          = dp_valid ? rd_word[15:9] : 7'd0;
    dp_x2          = dp_valid ? rd_word[8:2]  : 7'd0;
    dp_t           = dp_valid ? rd_word[1:0]  : 2'd0;
    dp_epoch_start = eps_q;
    epoch          = epoch_q;
    done           = (state_q == StDone);
    converged      = conv_q;
  end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Scoreboard bench for perceptron_train_ctrl: stimulus queues expected transfers and run
// results, a monitor pops and checks them, and a responder process models the datapath.
module tb_perceptron_train_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] n_samples = 7'd0;
  logic       wr_en = 1'b0;
  logic [6:0] wr_x1 = 7'd0;
  logic [6:0] wr_x2 = 7'd0;
  logic [1:0] wr_t = 2'd0;
  logic       dp_ready = 1'b0;
  logic       dp_ack = 1'b0;
  logic       dp_err = 1'b0;
  logic       load_ready, dp_valid, dp_epoch_start, done, converged;
  logic [6:0] dp_x1, dp_x2;
  logic [1:0] dp_t;
  logic [7:0] epoch;

  always #5 clk = ~clk;

  perceptron_train_ctrl #(
    .DEPTH      (64),
    .MAX_EPOCHS (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .n_samples      (n_samples),
    .wr_en          (wr_en),
    .wr_x1          (wr_x1),
    .wr_x2          (wr_x2),
    .wr_t           (wr_t),
    .load_ready     (load_ready),
    .dp_valid       (dp_valid),
    .dp_x1          (dp_x1),
    .dp_x2          (dp_x2),
    .dp_t           (dp_t),
    .dp_ready       (dp_ready),
    .dp_ack         (dp_ack),
    .dp_err         (dp_err),
    .dp_epoch_start (dp_epoch_start),
    .epoch          (epoch),
    .done           (done),
    .converged      (converged)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_smp[$];
  logic [15:0] exp_res[$];  // {epoch[15:8], converged[7], epoch_start pulses[6:0]}
  logic [15:0] vec[4];

  // Responder controls
  int err_mode = 0;
  int stall_left = 0;
  bit rdy_en = 1'b1;
  bit ack_en = 1'b1;
  bit man_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit err_fn(input int mode, input int ep, input int s);
    if (mode == 1) return (ep <= 2) && (s == 0);
    if (mode == 2) return 1'b1;
    return 1'b0;
  endfunction

  // Datapath model: acks each transfer one cycle later; error pattern set by err_mode.
  int r_ep = 0;
  int r_s = 0;
  bit r_xfer, r_e;
  initial begin
    forever begin
      @(negedge clk);
      if (load_ready) begin r_ep = 0; r_s = 0; end
      if (dp_epoch_start) begin r_ep++; r_s = 0; end
      r_xfer = dp_valid && dp_ready && !rst;
      r_e = r_xfer && err_fn(err_mode, r_ep, r_s);
      if (r_xfer) r_s++;
      @(posedge clk);
      #1;
      dp_ack = (r_xfer && ack_en) || man_ack;
      dp_err = r_e || man_ack;
      if (stall_left > 0 && dp_valid) begin
        dp_ready = 1'b0;
        stall_left--;
      end else begin
        dp_ready = rdy_en;
      end
    end
  end

  // Monitor
  int cyc = 0;
  int last_ack = -100;
  int pulses = 0;
  logic prev_done = 1'b0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_data = 16'd0;
  logic [15:0] m_exp;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_done = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (load_ready) pulses = 0;
        if (dp_epoch_start) begin
          pulses++;
          chk("epoch_start_with_valid", 32'(dp_valid), 32'd1);
        end
        if (prev_stall)
          chk("stall_hold", 32'({dp_valid, dp_x1, dp_x2, dp_t}), 32'({1'b1, prev_data}));
        if (dp_valid && dp_ready) begin
          if (exp_smp.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_xfer: got %0h expected none", {dp_x1, dp_x2, dp_t});
          end else begin
            m_exp = exp_smp.pop_front();
            chk("sample", 32'({dp_x1, dp_x2, dp_t}), 32'(m_exp));
          end
        end
        if (dp_ack) last_ack = cyc;
        if (done && !prev_done) begin
          if (exp_res.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got epoch %0d expected none", epoch);
          end else begin
            m_exp = exp_res.pop_front();
            chk("done_epoch", 32'(epoch), 32'(m_exp[15:8]));
            chk("converged", 32'(converged), 32'(m_exp[7]));
            chk("epoch_pulses", 32'(pulses), 32'(m_exp[6:0]));
            chk("ack_to_done", 32'(cyc - last_ack), 32'd2);
          end
        end
        prev_done = done;
        prev_stall = dp_valid && !dp_ready;
        prev_data = {dp_x1, dp_x2, dp_t};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_epochs(input int n, input int eps);
    for (int e = 0; e < eps; e++)
      for (int i = 0; i < n; i++) exp_smp.push_back(vec[i]);
  endtask

  task automatic load(input int n);
    start = 1'b1;
    n_samples = 7'(n);
    tick();
    start = 1'b0;
    chk("start_to_load_ready", 32'(load_ready), 32'd1);
    chk("done_cleared", 32'(done), 32'd0);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      {wr_x1, wr_x2, wr_t} = vec[i];
      tick();
    end
    wr_en = 1'b0;
    chk("write_to_dp_valid", 32'(dp_valid), 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 300) begin
      tick();
      k++;
    end
    chk("run_finished", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({load_ready, dp_valid, dp_x1, dp_x2, dp_t, dp_epoch_start, epoch, done,
                converged});
  endfunction

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_values", out_vec(), 32'd0);
    rst = 1'b0;
    tick();

    // Illegal sample counts are ignored
    start = 1'b1; n_samples = 7'd0;
    tick();
    start = 1'b0;
    chk("start_n0_ignored", 32'({load_ready, done}), 32'd0);
    start = 1'b1; n_samples = 7'd65;
    tick();
    start = 1'b0;
    chk("start_n65_ignored", 32'({load_ready, done}), 32'd0);

    // Clean single epoch
    vec[0] = {7'd3, 7'd3, 2'b01};
    vec[1] = {7'h7D, 7'h7D, 2'b11};
    err_mode = 0;
    push_epochs(2, 1);
    exp_res.push_back({8'd1, 1'b1, 7'd1});
    load(2);
    wait_done();

    // Errors in epochs 1-2, clean epoch 3 (restart from DONE)
    err_mode = 1;
    push_epochs(2, 3);
    exp_res.push_back({8'd3, 1'b1, 7'd3});
    load(2);
    wait_done();

    // Never converges: stops at the epoch limit
    err_mode = 2;
    push_epochs(2, 4);
    exp_res.push_back({8'd4, 1'b0, 7'd4});
    load(2);
    wait_done();
    repeat (4) tick();
    chk("held_after_limit", 32'({done, epoch, converged, dp_valid}), 32'({1'b1, 8'd4, 1'b0, 1'b0}));

    // Backpressure: dp_ready low for the first 5 PRESENT cycles
    vec[0] = {7'd5, 7'h7E, 2'b01};
    vec[1] = {7'h40, 7'd63, 2'b11};
    vec[2] = {7'd0, 7'd1, 2'b01};
    err_mode = 0;
    push_epochs(3, 1);
    exp_res.push_back({8'd1, 1'b1, 7'd1});
    stall_left = 5;
    load(3);
    wait_done();

    // Reset while waiting for an ack, with a start in the same cycle
    vec[0] = {7'd1, 7'd2, 2'b01};
    ack_en = 1'b0;
    push_epochs(1, 1);
    load(1);
    tick();
    chk("in_wait_ack", 32'(dp_valid), 32'd0);
    tick();
    rst = 1'b1;
    start = 1'b1;
    n_samples = 7'd2;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("reset_mid_wait_ack", out_vec(), 32'd0);
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    tick();
    tick();
    chk("ack_after_reset_ignored", out_vec(), 32'd0);
    ack_en = 1'b1;

    repeat (3) tick();
    chk("samples_consumed", 32'(exp_smp.size()), 32'd0);
    chk("results_consumed", 32'(exp_res.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
